wb_stage_pipe: RTL and testbench
================================

// Module: wb_stage_pipe
// PURPOSE
//  Parametrised MEM/WB pipeline register, successor to the dual-edge WB register.
//  Single-edge (posedge clk) design with valid/ready handshake, 2-entry skid buffer, sync flush.
//  Selects final write-back data (ALU/mem/PC+4/imm) and drives the register-file write port.
//  Counts retired instructions. Sits between the MEM stage and the register file / forwarding unit.
// PARAMETERS
//  DM_ADDRESS  9   PC width (bits)
//  DATA_W      32  data/immediate width
//  RA_W        5   register index width
//  SRC_W       3   write-back source select width
//  CNT_W       32  retired-instruction counter width
// PORTS
//  clk             in   1         clock; all state updates on posedge
//  rst             in   1         synchronous reset, active-high
//  flush           in   1         sync squash of all held entries
//  in_valid        in   1         MEM stage presents an instruction
//  in_ready        out  1         registered; buffer can accept this cycle
//  mem_rd_data_in  in   DATA_W    data-memory read data
//  alu_result_in   in   DATA_W    ALU result
//  pc_in           in   DM_ADDRESS  instruction PC
//  imm_in          in   DATA_W    immediate
//  reg_wrt_en_in   in   1         instruction writes a register
//  reg_wrt_src_in  in   SRC_W     write-back source select
//  reg_dst_in      in   RA_W      destination register
//  out_valid       out  1         head entry valid
//  out_ready       in   1         register file/consumer accepts head
//  wb_data         out  DATA_W    selected write-back data of head
//  wb_en           out  1         out_valid & out_ready & reg_wrt_en & (reg_dst != 0)
//  wb_dst          out  RA_W      head destination register
//  retire_cnt      out  CNT_W     retired-instruction count
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state EMPTY, out_valid=0, in_ready=0 while rst high, 1 first cycle after;
//    wb_data/wb_dst/retire_cnt=0; entry payloads cleared to 0.
//  - Accept = in_valid & in_ready; retire = out_valid & out_ready.
//  - FSM (occupancy): EMPTY, ONE (head valid), TWO (head + skid valid).
//    EMPTY: accept -> ONE (payload to head).
//    ONE: accept&!retire -> TWO (payload to skid); !accept&retire -> EMPTY;
//         accept&retire -> ONE (payload to head).
//    TWO: retire -> ONE (skid moves to head); no accept possible (in_ready=0).
//  - in_ready registered: 1 in next cycle iff next state != TWO.
//  - Latency: accepted in cycle N -> out_valid in cycle N+1 (EMPTY, or ONE with retire).
//  - Order strictly preserved; no entry dropped or duplicated under any ready pattern.
//  - flush=1: next state EMPTY, same-cycle accept discarded, same-cycle retire still counts and
//    wb_en still fires (head commits before squash). flush has priority over accept; rst over flush.
//  - wb_data select on head reg_wrt_src: 0 ALU, 1 mem data, 2 zero-extended PC+4 (DATA_W),
//    3 imm, other codes -> ALU result. Combinational from head register.
//  - reg_dst=0: wb_en forced 0 but the instruction still retires and counts.
//  - retire_cnt increments by 1 per retire, wraps modulo 2^CNT_W with no saturation.
// STRUCTURE
//  - Package wb_pkg: wb_src_e enum (WB_ALU=0, WB_MEM=1, WB_PC4=2, WB_IMM=3), occupancy enum,
//    wb_entry_t packed struct {mem_rd_data, alu_result, pc, imm, reg_wrt_en, reg_wrt_src, reg_dst}.
//  - Sub-module wb_skid_buf: generic 2-entry skid buffer over wb_entry_t (FSM + head/skid regs).
//  - Top level adds the write-back mux, wb_en qualification, and the retire counter.
// TESTING
//  - Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, retire_cnt=0;
//    in_ready=1 one cycle after release.
//  - Streaming: out_ready=1, 8 back-to-back ALU ops (reg_dst=1..8) -> wb_en each cycle from N+1,
//    wb_dst 1..8 in order, retire_cnt=8.
//  - Backpressure: out_ready=0 after 2 accepts -> in_ready=0, state TWO; raise out_ready ->
//    both entries retire in order, none lost.
//  - Flush in TWO with in_valid=1, out_ready=0 -> out_valid=0 next cycle; new input discarded;
//    retire_cnt unchanged.
//  - Source mux: src=2, pc=0x1FC -> wb_data=0x200; src=3, imm=0xFFFF_FFF0 -> wb_data=0xFFFF_FFF0;
//    src=1 with reg_dst=0 -> wb_en=0, retire_cnt+1.
//  - Wrap: CNT_W=4, 17 retires -> retire_cnt=1.

Source files
------------

// File: rtl/wb_stage_pipe_pkg.sv
// Shared types for the MEM/WB write-back stage: source selects, occupancy states,
// the per-instruction entry carried through the skid buffer, and the write-back data select.
package wb_pkg;

    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;
    localparam int RA_W       = 5;
    localparam int SRC_W      = 3;

    typedef enum logic [SRC_W-1:0] {
        WB_ALU = 3'd0,
        WB_MEM = 3'd1,
        WB_PC4 = 3'd2,
        WB_IMM = 3'd3
    } wb_src_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    typedef struct packed {
        logic [DATA_W-1:0]     mem_rd_data;
        logic [DATA_W-1:0]     alu_result;
        logic [DM_ADDRESS-1:0] pc;
        logic [DATA_W-1:0]     imm;
        logic                  reg_wrt_en;
        logic [SRC_W-1:0]      reg_wrt_src;
        logic [RA_W-1:0]       reg_dst;
    } wb_entry_t;

    // Unassigned source codes fall back to the ALU result.
    function automatic logic [DATA_W-1:0] wb_select(input wb_entry_t e);
        logic [DATA_W-1:0] r;
        r = e.alu_result;
        case (e.reg_wrt_src)
            WB_MEM:  r = e.mem_rd_data;
            WB_PC4:  r = DATA_W'(e.pc) + DATA_W'(4);
            WB_IMM:  r = e.imm;
            default: r = e.alu_result;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// Handshake and payload bundle between the MEM stage, the write-back stage and the register file.
interface wb_stage_pipe_if #(
    parameter int CNT_W = 32
);
    import wb_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     mem_rd_data_in;
    logic [DATA_W-1:0]     alu_result_in;
    logic [DM_ADDRESS-1:0] pc_in;
    logic [DATA_W-1:0]     imm_in;
    logic                  reg_wrt_en_in;
    logic [SRC_W-1:0]      reg_wrt_src_in;
    logic [RA_W-1:0]       reg_dst_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_en;
    logic [RA_W-1:0]       wb_dst;
    logic [CNT_W-1:0]      retire_cnt;

    modport slave (
        input  in_valid, mem_rd_data_in, alu_result_in, pc_in, imm_in,
               reg_wrt_en_in, reg_wrt_src_in, reg_dst_in, out_ready,
        output in_ready, out_valid, wb_data, wb_en, wb_dst, retire_cnt
    );

    modport master (
        output in_valid, mem_rd_data_in, alu_result_in, pc_in, imm_in,
               reg_wrt_en_in, reg_wrt_src_in, reg_dst_in, out_ready,
        input  in_ready, out_valid, wb_data, wb_en, wb_dst, retire_cnt
    );

endinterface

// File: rtl/wb_stage_pipe_skid_buf.sv
// Two-entry skid buffer over wb_entry_t: a head register feeding the consumer plus one
// overflow slot, so in_ready can be registered without losing an entry under backpressure.
module wb_skid_buf
    import wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush_i,
    input  logic      in_valid_i,
    input  wb_entry_t in_data_i,
    output logic      in_ready_o,
    output logic      out_valid_o,
    input  logic      out_ready_i,
    output wb_entry_t head_o
);

    occ_e      state_q, state_d;
    wb_entry_t head_q, head_d;
    wb_entry_t skid_q, skid_d;
    logic      in_ready_q;
    logic      accept, retire;

    assign accept      = in_valid_i & in_ready_q;
    assign retire      = out_valid_o & out_ready_i;
    assign out_valid_o = (state_q != OCC_EMPTY);
    assign in_ready_o  = in_ready_q;
    assign head_o      = head_q;

    // Flush empties the buffer and drops any same-cycle accept; the head may still retire.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_d  = in_data_i;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && !retire) begin
                        skid_d  = in_data_i;
                        state_d = OCC_TWO;
                    end else if (!accept && retire) begin
                        state_d = OCC_EMPTY;
                    end else if (accept && retire) begin
                        head_d  = in_data_i;
                    end
                end
                OCC_TWO: begin
                    if (retire) begin
                        head_d  = skid_q;
                        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != OCC_TWO);
        end
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register: skid-buffered handshake, write-back source select,
// register-file write qualification and a wrapping retired-instruction counter.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    wb_stage_pipe_if.slave   bus
);

    wb_entry_t        in_entry;
    wb_entry_t        head;
    logic             out_valid;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    assign in_entry.mem_rd_data = bus.mem_rd_data_in;
    assign in_entry.alu_result  = bus.alu_result_in;
    assign in_entry.pc          = bus.pc_in;
    assign in_entry.imm         = bus.imm_in;
    assign in_entry.reg_wrt_en  = bus.reg_wrt_en_in;
    assign in_entry.reg_wrt_src = bus.reg_wrt_src_in;
    assign in_entry.reg_dst     = bus.reg_dst_in;

    wb_skid_buf u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (bus.in_valid),
        .in_data_i   (in_entry),
        .in_ready_o  (bus.in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (bus.out_ready),
        .head_o      (head)
    );

    assign retire        = out_valid & bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.wb_data   = wb_select(head);
    assign bus.wb_dst    = head.reg_dst;
    // x0 writes are suppressed here, but the instruction still retires and is counted.
    assign bus.wb_en     = retire & head.reg_wrt_en & (head.reg_dst != '0);

    assign retire_cnt_d   = retire ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
    assign bus.retire_cnt = retire_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: a 32-bit counter instance and a 4-bit counter instance
// share one stimulus stream so counter wrap is observed alongside the main behaviour.
module tb_wb_stage_pipe;
    import wb_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  inValid = 1'b0;
    logic                  outReady = 1'b0;
    logic [DATA_W-1:0]     memData = '0;
    logic [DATA_W-1:0]     aluRes = '0;
    logic [DM_ADDRESS-1:0] pcVal = '0;
    logic [DATA_W-1:0]     immVal = '0;
    logic                  wrtEn = 1'b0;
    logic [SRC_W-1:0]      wrtSrc = '0;
    logic [RA_W-1:0]       dstReg = '0;

    int total = 0;
    int bad   = 0;

    wb_stage_pipe_if #(.CNT_W(32)) bus  ();
    wb_stage_pipe_if #(.CNT_W(4))  busW ();

    assign bus.in_valid        = inValid;
    assign bus.out_ready       = outReady;
    assign bus.mem_rd_data_in  = memData;
    assign bus.alu_result_in   = aluRes;
    assign bus.pc_in           = pcVal;
    assign bus.imm_in          = immVal;
    assign bus.reg_wrt_en_in   = wrtEn;
    assign bus.reg_wrt_src_in  = wrtSrc;
    assign bus.reg_dst_in      = dstReg;
    assign busW.in_valid       = inValid;
    assign busW.out_ready      = outReady;
    assign busW.mem_rd_data_in = memData;
    assign busW.alu_result_in  = aluRes;
    assign busW.pc_in          = pcVal;
    assign busW.imm_in         = immVal;
    assign busW.reg_wrt_en_in  = wrtEn;
    assign busW.reg_wrt_src_in = wrtSrc;
    assign busW.reg_dst_in     = dstReg;

    wb_stage_pipe #(.CNT_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    wb_stage_pipe #(.CNT_W(4)) dutWrap (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (busW)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [SRC_W-1:0] src,
                                 input logic [RA_W-1:0] dst, input logic [DATA_W-1:0] alu,
                                 input logic [DATA_W-1:0] mem, input logic [DM_ADDRESS-1:0] pc,
                                 input logic [DATA_W-1:0] imm, input logic we,
                                 input logic ordy, input logic fl);
        inValid  = v;
        wrtSrc   = src;
        dstReg   = dst;
        aluRes   = alu;
        memData  = mem;
        pcVal    = pc;
        immVal   = imm;
        wrtEn    = we;
        outReady = ordy;
        flush    = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for three cycles while the MEM stage is already presenting.
        applyStimulus(1'b1, 3'd0, 5'd5, 32'h55, 32'h0, 9'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick(); tick(); tick();
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("rst_retire_cnt", 64'(bus.retire_cnt), 64'd0);
        checkOutput("rst_wb_data", 64'(bus.wb_data), 64'd0);
        checkOutput("rst_wb_dst", 64'(bus.wb_dst), 64'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("rel_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rel_out_valid", 64'(bus.out_valid), 64'd0);

        // Back-to-back ALU ops with the consumer always ready.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 3'd0, 5'(i), 32'(i * 17), 32'h0, 9'h0, 32'h0, 1'b1, 1'b1, 1'b0);
            tick();
            checkOutput("str_out_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("str_wb_en", 64'(bus.wb_en), 64'd1);
            checkOutput("str_wb_dst", 64'(bus.wb_dst), 64'(i));
            checkOutput("str_wb_data", 64'(bus.wb_data), 64'(i * 17));
            checkOutput("str_cnt", 64'(bus.retire_cnt), 64'(i - 1));
        end
        applyStimulus(1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("str_drain_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("str_cnt_final", 64'(bus.retire_cnt), 64'd8);

        // Backpressure: fill both slots, offer a third that must be refused.
        applyStimulus(1'b1, 3'd0, 5'd9, 32'hA, 32'h0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("bp_one_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("bp_one_wb_en", 64'(bus.wb_en), 64'd0);
        applyStimulus(1'b1, 3'd0, 5'd10, 32'hB, 32'h0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("bp_two_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("bp_two_dst", 64'(bus.wb_dst), 64'd9);
        applyStimulus(1'b1, 3'd0, 5'd11, 32'hC, 32'h0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("bp_hold_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("bp_hold_dst", 64'(bus.wb_dst), 64'd9);
        applyStimulus(1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_rel_wb_en", 64'(bus.wb_en), 64'd1);
        tick();
        checkOutput("bp_second_dst", 64'(bus.wb_dst), 64'd10);
        checkOutput("bp_second_data", 64'(bus.wb_data), 64'hB);
        checkOutput("bp_second_ready", 64'(bus.in_ready), 64'd1);
        tick();
        checkOutput("bp_empty", 64'(bus.out_valid), 64'd0);
        checkOutput("bp_cnt", 64'(bus.retire_cnt), 64'd10);

        // Flush while full and stalled; the new input offered alongside is dropped.
        applyStimulus(1'b1, 3'd0, 5'd12, 32'hD, 32'h0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd0, 5'd13, 32'hE, 32'h0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("fl_pre_ready", 64'(bus.in_ready), 64'd0);
        applyStimulus(1'b1, 3'd0, 5'd14, 32'hF, 32'h0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("fl_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("fl_cnt", 64'(bus.retire_cnt), 64'd10);
        tick();
        checkOutput("fl_discard_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("fl_discard_cnt", 64'(bus.retire_cnt), 64'd10);

        // Write-back source select.
        applyStimulus(1'b1, 3'd2, 5'd3, 32'h1234, 32'h0, 9'h1FC, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("mux_pc4", 64'(bus.wb_data), 64'h200);
        checkOutput("mux_pc4_stall_en", 64'(bus.wb_en), 64'd0);
        applyStimulus(1'b1, 3'd3, 5'd4, 32'h1, 32'h0, 9'h0, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0);
        checkOutput("mux_pc4_wb_en", 64'(bus.wb_en), 64'd1);
        tick();
        checkOutput("mux_imm", 64'(bus.wb_data), 64'hFFFF_FFF0);
        checkOutput("mux_imm_cnt", 64'(bus.retire_cnt), 64'd11);
        applyStimulus(1'b1, 3'd1, 5'd0, 32'h77, 32'hDEAD_BEEF, 9'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("mux_mem", 64'(bus.wb_data), 64'hDEAD_BEEF);
        checkOutput("mux_x0_wb_en", 64'(bus.wb_en), 64'd0);
        checkOutput("mux_x0_valid", 64'(bus.out_valid), 64'd1);
        applyStimulus(1'b1, 3'd5, 5'd6, 32'h55, 32'h99, 9'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("mux_other_src", 64'(bus.wb_data), 64'h55);
        checkOutput("mux_other_wb_en", 64'(bus.wb_en), 64'd1);
        checkOutput("mux_x0_counted", 64'(bus.retire_cnt), 64'd13);
        applyStimulus(1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("mux_drain_cnt", 64'(bus.retire_cnt), 64'd14);

        // Flush coinciding with a retire: the head still commits and counts.
        applyStimulus(1'b1, 3'd0, 5'd7, 32'h70, 32'h0, 9'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd0, 5'd8, 32'h80, 32'h0, 9'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("flr_wb_en", 64'(bus.wb_en), 64'd1);
        tick();
        applyStimulus(1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("flr_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("flr_cnt", 64'(bus.retire_cnt), 64'd15);
        checkOutput("flr_cnt4", 64'(busW.retire_cnt), 64'd15);
        tick();
        checkOutput("flr_no_dup", 64'(bus.retire_cnt), 64'd15);

        // Counter wrap: 17 retires from a fresh reset.
        rst = 1'b1;
        tick();
        checkOutput("wrap_rst_cnt4", 64'(busW.retire_cnt), 64'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 3'd0, 5'((i % 31) + 1), 32'(i), 32'h0, 9'h0, 32'h0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("wrap_cnt32", 64'(bus.retire_cnt), 64'd17);
        checkOutput("wrap_cnt4", 64'(busW.retire_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
